neuron_controller: RTL
======================

# neuron_controller

Sequencer for the single-neuron multiply-accumulate datapath. On a start request it clears the accumulator, steps an input/weight index through N pairs while pulsing the accumulator load, then captures the activated result. It presents that result on a valid/ready output handshake. It sits between the layer-level scheduler (start/result consumer) and one `datapath` instance plus its input/weight memories.

## Interface
- `N`, 16: number of input/weight pairs per neuron evaluation; legal range 1..65535.
- `IDX_W`, 16: width of the index bus; `N-1` must fit in `IDX_W` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request one neuron evaluation; sampled only in IDLE, or in OUT when accepted together with `out_ready`.
- `idx` output IDX_W: pair index driven to the input/weight memories (combinational read, data valid in the same cycle).
- `reg_rst` output 1: synchronous accumulator clear to the datapath register.
- `ld` output 1: accumulator load enable to the datapath register.
- `res_in` input 16: activated accumulator value from the datapath.
- `result` output 16: captured result.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts `result`.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, CLR, ACC, SETTLE, OUT; 16-bit-capable counter `cnt` (IDX_W bits).
- IDLE: every control output is 0. `start=1` moves to CLR.
- CLR (1 cycle): `reg_rst=1`, `idx=0`, `ld=0`, `cnt<=0`; then moves to ACC.
- ACC: `idx=cnt`, `ld=1`, `cnt<=cnt+1` each cycle.
  - When `cnt==N-1`, moves to SETTLE and clears `cnt` to 0 (no wrap past N-1).
- SETTLE (1 cycle): `ld=0`, `idx` held at N-1, `result<=res_in`; then moves to OUT.
- OUT: `out_valid=1`, `result` stable.
  - `out_ready=1` completes the transfer.
  - If `start=1` in the same cycle, moves to CLR (back-to-back evaluation); otherwise moves to IDLE.
- `start` while busy (CLR/ACC/SETTLE) is ignored; it is not queued.
- Accumulator arithmetic is owned by the datapath. The controller guarantees exactly N `ld` pulses between one `reg_rst` and the capture.
- `N=1`: ACC lasts exactly one cycle.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt=0`, `idx=0`, `reg_rst=0`, `ld=0`, `result=0`, `out_valid=0`, `busy=0`.
- Reset asserted mid-operation aborts immediately. The accumulator is not cleared by this block; the next CLR clears it.
- Start-to-result latency: `start` sampled at edge E gives CLR in cycle E..E+1 and ACC in edges E+2..E+N+1. `result` is captured at edge E+N+2, and `out_valid` is high from E+N+2 on. That is N+2 cycles (18 for N=16).
- `ld` and `idx` are Moore outputs (registered state decode), glitch-free relative to `clk`.
- `out_valid` is never deasserted without `out_ready`; `result` does not change while `out_valid=1`.
- Back-to-back throughput: one result per N+2 cycles with `out_ready` tied high.

## Configuration
- `NEURON_CTRL_STALL_EN` defined: adds input port `stall` (1 bit).
  - In ACC with `stall=1`: `ld=0`, `cnt` and `idx` held, and the state is unchanged.
  - `stall` is ignored in all other states.
  - Latency grows by exactly the number of stalled ACC cycles.
- Undefined: no `stall` port; ACC never pauses.

## Test plan
- Reset then `start` pulse with N=4, all inputs 0x02, weights 0x03 (real datapath) -> `reg_rst` one cycle, `ld` high 4 cycles with idx 0,1,2,3, accumulator 0x0018. `result` equals activation of 0x0018 and `out_valid` rises 6 cycles after the start edge.
- Inputs 0x81 (−1), weights 0x05, N=4 -> `ld` count 4, `result` equals activation of the datapath's signed sum. No extra or missing `ld`.
- `out_ready` held low 10 cycles in OUT, then pulsed -> `result` and `out_valid` stable throughout, IDLE on the next cycle. A `start` asserted during ACC is ignored (exactly one evaluation).
- `out_ready=1` and `start=1` in the same OUT cycle, N=16 -> next cycle CLR and the next `out_valid` 18 cycles later.
- `rst_n` low at ACC `idx=7` -> all outputs 0 asynchronously. A new start produces a full 16-pulse sequence from `idx=0`.
- With `NEURON_CTRL_STALL_EN`, N=16: `stall` high 3 cycles at `idx=5` -> `idx` held at 5, `ld=0` for 3 cycles, total latency 21 cycles.

Source files
------------

// File: rtl/neuron_controller.sv
// Sequencer for one neuron MAC pass: clear, N load pulses, settle, capture, then valid/ready output.
// Optional `NEURON_CTRL_STALL_EN adds a `stall` input that pauses the ACC phase.
module neuron_controller #(
  parameter int N     = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NEURON_CTRL_STALL_EN
  input  logic             stall,
`endif
  output logic [IDX_W-1:0] idx,
  output logic             reg_rst,
  output logic             ld,
  input  logic [15:0]      res_in,
  output logic [15:0]      result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_SETTLE,
    S_OUT
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_reg_rst;
  logic             r_ld;
  logic [15:0]      r_result;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_stall;

`ifdef NEURON_CTRL_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // r_ld is only ever set in ACC, so the stall mask needs no state qualifier;
  // masking in the same cycle keeps the datapath from loading a held index twice.
  assign ld        = r_ld & ~w_stall;
  assign idx       = r_idx;
  assign reg_rst   = r_reg_rst;
  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // NOTE: every state and output register is written with <= so all of them
  // update together from pre-edge values; blocking = here would create
  // order-dependent races between the state and its decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_reg_rst   <= 1'b0;
      r_ld        <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLR;
            r_reg_rst <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_CLR: begin
          r_state   <= S_ACC;
          r_reg_rst <= 1'b0;
          r_ld      <= 1'b1;
          r_idx     <= '0;
          r_cnt     <= '0;
        end
        S_ACC: begin
          if (!w_stall) begin
            if (r_cnt == LAST) begin
              r_state <= S_SETTLE;
              r_cnt   <= '0;
              r_ld    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_idx <= r_cnt + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          r_state     <= S_OUT;
          r_result    <= res_in;
          r_out_valid <= 1'b1;
          r_idx       <= '0;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state   <= S_CLR;
              r_reg_rst <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_reg_rst   <= 1'b0;
          r_ld        <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
